// File: rtl/video_mode_ctrl.sv
// Video format lock controller: synchronizes raw vsync, samples the measured
// active size once per frame and latches a format after it has been stable.
module video_mode_ctrl #(
  parameter int STABLE_FRAMES = 4,
  parameter int DROP_FRAMES   = 2
) (
  input  logic        clk_148,
  input  logic        rst_n,
  input  logic        vs,
  input  logic [15:0] h_active,
  input  logic [15:0] v_active,
  input  logic        video_lost,
  output logic        locked,
  output logic [15:0] lock_h,
  output logic [15:0] lock_v,
  output logic [2:0]  mode_id,
  output logic        reconfig,
  output logic        pattern_sel,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    NOSIG   = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_AT = 4'(STABLE_FRAMES - 1);
  localparam logic [3:0] DROP_AT = 4'(DROP_FRAMES);

  state_t      state_q, state_d;
  logic        vs_s1_q, vs_s2_q, vs_s3_q;
  logic [1:0]  sync_vld_q, sync_vld_d;
  logic        arm_q, arm_d;
  logic        tick;
  logic [15:0] cand_h_q, cand_h_d, cand_v_q, cand_v_d;
  logic [15:0] lock_h_q, lock_h_d, lock_v_q, lock_v_d;
  logic [3:0]  match_cnt_q, match_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [3:0]  match_inc, miss_inc;
  logic        reconfig_q, reconfig_d;
  logic [2:0]  mode_id_q, mode_id_d;
  logic        cand_hit, lock_hit;

  function automatic logic [2:0] decode_mode(input logic [15:0] h, input logic [15:0] v);
    if (h == 16'd640  && v == 16'd480)  return 3'd1;
    if (h == 16'd1280 && v == 16'd720)  return 3'd2;
    if (h == 16'd1920 && v == 16'd1080) return 3'd3;
    if (h == 16'd3840 && v == 16'd2160) return 3'd4;
    return 3'd0;
  endfunction

  // sync_vld marks when vs_s2 reflects real input; arming only on an observed
  // low level keeps a vs already high at reset release from producing a tick.
  assign sync_vld_d = {sync_vld_q[0], 1'b1};
  assign arm_d      = arm_q | (sync_vld_q[1] & ~vs_s2_q);
  assign tick       = vs_s2_q & ~vs_s3_q & arm_q;

  assign cand_hit  = (h_active == cand_h_q) && (v_active == cand_v_q) &&
                     (h_active != 16'd0) && (v_active != 16'd0);
  assign lock_hit  = (h_active == lock_h_q) && (v_active == lock_v_q);
  assign match_inc = (match_cnt_q == 4'hF) ? match_cnt_q : match_cnt_q + 4'd1;
  assign miss_inc  = (miss_cnt_q == 4'hF) ? miss_cnt_q : miss_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    cand_h_d    = cand_h_q;
    cand_v_d    = cand_v_q;
    lock_h_d    = lock_h_q;
    lock_v_d    = lock_v_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    reconfig_d  = 1'b0;
    if (video_lost) begin
      state_d = NOSIG;
    end else begin
      case (state_q)
        NOSIG: begin
          state_d     = ACQUIRE;
          cand_h_d    = 16'd0;
          cand_v_d    = 16'd0;
          match_cnt_d = 4'd0;
          miss_cnt_d  = 4'd0;
        end
        ACQUIRE: begin
          if (tick) begin
            if (cand_hit) begin
              match_cnt_d = match_inc;
              if (match_inc == LOCK_AT) begin
                state_d    = LOCKED;
                lock_h_d   = cand_h_q;
                lock_v_d   = cand_v_q;
                miss_cnt_d = 4'd0;
                reconfig_d = 1'b1;
              end
            end else begin
              cand_h_d    = h_active;
              cand_v_d    = v_active;
              match_cnt_d = 4'd0;
            end
          end
        end
        LOCKED: begin
          if (tick) begin
            if (lock_hit) begin
              miss_cnt_d = 4'd0;
            end else begin
              miss_cnt_d = miss_inc;
              if (miss_inc == DROP_AT) begin
                state_d     = ACQUIRE;
                cand_h_d    = h_active;
                cand_v_d    = v_active;
                match_cnt_d = 4'd0;
                miss_cnt_d  = 4'd0;
              end
            end
          end
        end
        default: state_d = NOSIG;
      endcase
    end
    // Decoding the next-state values lets mode_id rise together with locked.
    mode_id_d = (state_d == LOCKED) ? decode_mode(lock_h_d, lock_v_d) : 3'd0;
  end

  always_ff @(posedge clk_148) begin
    if (!rst_n) begin
      state_q     <= NOSIG;
      vs_s1_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      vs_s3_q     <= 1'b0;
      sync_vld_q  <= 2'b00;
      arm_q       <= 1'b0;
      cand_h_q    <= 16'd0;
      cand_v_q    <= 16'd0;
      lock_h_q    <= 16'd0;
      lock_v_q    <= 16'd0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      reconfig_q  <= 1'b0;
      mode_id_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      vs_s1_q     <= vs;
      vs_s2_q     <= vs_s1_q;
      vs_s3_q     <= vs_s2_q;
      sync_vld_q  <= sync_vld_d;
      arm_q       <= arm_d;
      cand_h_q    <= cand_h_d;
      cand_v_q    <= cand_v_d;
      lock_h_q    <= lock_h_d;
      lock_v_q    <= lock_v_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      reconfig_q  <= reconfig_d;
      mode_id_q   <= mode_id_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign pattern_sel = ~locked;
  assign lock_h      = lock_h_q;
  assign lock_v      = lock_v_q;
  assign mode_id     = mode_id_q;
  assign reconfig    = reconfig_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: every lock acquisition is pushed as an
// expected {mode,h,v} record and popped by a monitor on each reconfig pulse.
module tb_video_mode_ctrl;

  logic        clk_148 = 1'b0;
  logic        rst_n;
  logic        vs;
  logic [15:0] h_active, v_active;
  logic        video_lost;
  logic        locked, reconfig, pattern_sel;
  logic [15:0] lock_h, lock_v;
  logic [2:0]  mode_id;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [34:0] exp_q[$];
  logic        reconfig_prev = 1'b0;

  video_mode_ctrl #(.STABLE_FRAMES(4), .DROP_FRAMES(2)) dut (
    .clk_148(clk_148), .rst_n(rst_n), .vs(vs), .h_active(h_active),
    .v_active(v_active), .video_lost(video_lost), .locked(locked),
    .lock_h(lock_h), .lock_v(lock_v), .mode_id(mode_id), .reconfig(reconfig),
    .pattern_sel(pattern_sel), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk_148 = ~clk_148;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic frame(input logic [15:0] h, input logic [15:0] v);
    h_active = h;
    v_active = v;
    @(negedge clk_148);
    vs = 1'b1;
    repeat (6) @(negedge clk_148);
    vs = 1'b0;
    repeat (6) @(negedge clk_148);
  endtask

  task automatic frames(input logic [15:0] h, input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) frame(h, v);
  endtask

  task automatic expect_lock(input logic [2:0] m, input logic [15:0] h, input logic [15:0] v);
    exp_q.push_back({m, h, v});
  endtask

  // monitor / scoreboard
  always @(negedge clk_148) begin
    total++;
    if (pattern_sel !== ~locked) begin
      bad++;
      $display("FAIL pattern_sel: got %0b expected %0b", pattern_sel, ~locked);
    end
    if (reconfig === 1'b1) begin
      total++;
      if (reconfig_prev) begin
        bad++;
        $display("FAIL reconfig_double: got 2 consecutive pulses expected 1");
      end
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL reconfig_unexpected: got pulse lock=%0dx%0d expected none", lock_h, lock_v);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if ({mode_id, lock_h, lock_v} !== e || locked !== 1'b1) begin
          bad++;
          $display("FAIL lock_record: got mode=%0d %0dx%0d locked=%0b expected mode=%0d %0dx%0d locked=1",
                   mode_id, lock_h, lock_v, locked, e[34:32], e[31:16], e[15:0]);
        end
      end
    end
    reconfig_prev <= reconfig;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of test expected end within budget");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0; vs = 1'b0; h_active = 16'd0; v_active = 16'd0; video_lost = 1'b1;
    repeat (4) @(negedge clk_148);
    chk("rst_locked", locked, 0);
    chk("rst_pattern", pattern_sel, 1);
    chk("rst_mode", mode_id, 0);
    chk("rst_lock_h", lock_h, 0);
    chk("rst_reconfig", reconfig, 0);
    rst_n = 1'b1;
    video_lost = 1'b0;
    repeat (4) @(negedge clk_148);

    // 1920x1080 locks after the 4th tick
    expect_lock(3'd3, 16'd1920, 16'd1080);
    frames(16'd1920, 16'd1080, 3);
    chk("fhd_not_yet", locked, 0);
    frame(16'd1920, 16'd1080);
    chk("fhd_locked", locked, 1);
    chk("fhd_mode", mode_id, 3);
    chk("fhd_pattern", pattern_sel, 0);

    // format change: two misses drop lock, then 720p locks
    frame(16'd1280, 16'd720);
    chk("drop_miss1_locked", locked, 1);
    frame(16'd1280, 16'd720);
    chk("drop_miss2_unlocked", locked, 0);
    expect_lock(3'd2, 16'd1280, 16'd720);
    frames(16'd1280, 16'd720, 3);
    chk("hd_locked", locked, 1);
    chk("hd_mode", mode_id, 2);

    // single glitch frame is tolerated
    frame(16'd1280, 16'd721);
    frame(16'd1280, 16'd720);
    chk("glitch_locked", locked, 1);
    frame(16'd1280, 16'd721);
    frame(16'd1280, 16'd722);
    chk("two_miss_unlocked", locked, 0);

    // 720,720,1080x4: only the 4th consecutive 1080p frame locks
    frames(16'd1280, 16'd720, 2);
    frames(16'd1920, 16'd1080, 3);
    chk("mixed_not_yet", locked, 0);
    expect_lock(3'd3, 16'd1920, 16'd1080);
    frame(16'd1920, 16'd1080);
    chk("mixed_locked", locked, 1);
    chk("mixed_mode", mode_id, 3);

    // video_lost coincident with a tick
    @(negedge clk_148);
    vs = 1'b1;
    @(negedge clk_148);
    @(negedge clk_148);
    video_lost = 1'b1;
    @(negedge clk_148);
    chk("lost_locked", locked, 0);
    chk("lost_mode", mode_id, 0);
    chk("lost_pattern", pattern_sel, 1);
    chk("lost_state", state_dbg, 0);
    video_lost = 1'b0;
    repeat (4) @(negedge clk_148);
    vs = 1'b0;
    repeat (6) @(negedge clk_148);

    // re-lock at the same format still pulses reconfig
    expect_lock(3'd3, 16'd1920, 16'd1080);
    frames(16'd1920, 16'd1080, 4);
    chk("relock_locked", locked, 1);

    // 1000x600 locks with unknown mode; 0x0 never locks
    frames(16'd1000, 16'd600, 2);
    expect_lock(3'd0, 16'd1000, 16'd600);
    frames(16'd1000, 16'd600, 4);
    chk("odd_locked", locked, 1);
    chk("odd_mode", mode_id, 0);
    frames(16'd0, 16'd0, 10);
    chk("zero_unlocked", locked, 0);
    chk("zero_hold_h", lock_h, 1000);
    chk("zero_hold_v", lock_v, 600);
    frames(16'd0, 16'd480, 5);
    chk("zero_w_unlocked", locked, 0);

    // remaining decodes
    expect_lock(3'd1, 16'd640, 16'd480);
    frames(16'd640, 16'd480, 4);
    chk("vga_mode", mode_id, 1);
    expect_lock(3'd4, 16'd3840, 16'd2160);
    frames(16'd3840, 16'd2160, 5);
    chk("uhd_mode", mode_id, 4);
    frames(16'd1920, 16'd1080, 2);
    expect_lock(3'd3, 16'd1920, 16'd1080);
    frames(16'd1920, 16'd1080, 3);
    chk("fhd2_locked", locked, 1);

    // one-cycle reset while locked, vs held high across release
    @(negedge clk_148);
    vs = 1'b1;
    repeat (4) @(negedge clk_148);
    rst_n = 1'b0;
    @(negedge clk_148);
    chk("mrst_locked", locked, 0);
    chk("mrst_pattern", pattern_sel, 1);
    chk("mrst_mode", mode_id, 0);
    chk("mrst_lock_h", lock_h, 0);
    chk("mrst_lock_v", lock_v, 0);
    chk("mrst_reconfig", reconfig, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk_148);
    chk("mrst_hold_unlocked", locked, 0);
    vs = 1'b0;
    repeat (6) @(negedge clk_148);
    frames(16'd1920, 16'd1080, 3);
    chk("mrst_no_early_tick", locked, 0);
    expect_lock(3'd3, 16'd1920, 16'd1080);
    frame(16'd1920, 16'd1080);
    chk("mrst_relocked", locked, 1);

    repeat (4) @(negedge clk_148);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
